// File: rtl/stage_addrgen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stage_addrgen_pkg
// Brief    : Shared state encoding and base-table constants for stage_addrgen.
// Revision : 1.0 - initial release
// ============================================================================
package stage_addrgen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned c_LAST_STAGE_DEFAULT = 11;
    localparam int unsigned c_RD_STRIDE          = 256;
    localparam int unsigned c_BASE_ENTRIES       = 16;

    function automatic int unsigned rd_base_value(input int unsigned k);
        return k * c_RD_STRIDE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stage_basetable.sv
`default_nettype none
// ============================================================================
// Module   : stage_basetable
// Brief    : Per-stage read base table plus step offset adder.
// Revision : 1.0 - initial release
// ============================================================================
module stage_basetable
    import stage_addrgen_pkg::*;
#(
    parameter int Na = 8,
    parameter int Nc = 4,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [Nc-1:0] count_stage,
    input  logic [Na-1:0] count_step,
    output logic [AW-1:0] base_addr
);

    logic [AW-1:0] rd_base_q [c_BASE_ENTRIES];
    logic [AW-1:0] rd_base_d [c_BASE_ENTRIES];

    // Table is (re)loaded on reset and otherwise holds its contents.
    always_comb begin
        for (int k = 0; k < c_BASE_ENTRIES; k++) begin
            rd_base_d[k] = rst ? AW'(rd_base_value(k)) : rd_base_q[k];
        end
    end

    always_ff @(posedge clk) begin
        rd_base_q <= rd_base_d;
    end

    assign base_addr = rd_base_q[count_stage] + AW'(count_step);

endmodule
`default_nettype wire

// File: rtl/stage_addrgen.sv
`default_nettype none
// ============================================================================
// Module   : stage_addrgen
// Brief    : Stage-driven read/write address generator with run/flush/done FSM.
// Revision : 1.0 - initial release
// ============================================================================
module stage_addrgen
    import stage_addrgen_pkg::*;
#(
    parameter int Na         = 8,
    parameter int Nc         = 4,
    parameter int Nd         = 16,
    parameter int AW         = 12,
    parameter int LAST_STAGE = stage_addrgen_pkg::c_LAST_STAGE_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [Na-1:0] count_step,
    input  logic [Nc-1:0] count_stage,
    input  logic [Nd-1:0] count_epoch,
    input  logic          last_step,
    input  logic [Nd-1:0] stop_epoch,
    output logic [AW-1:0] rd_addr,
    output logic          rd_en,
    output logic [AW-1:0] wr_addr,
    output logic          wr_en,
    output logic          acc_clr,
    output logic          epoch_done
);

    localparam logic [Nc-1:0] c_LAST_STAGE = Nc'(LAST_STAGE);

    state_e        state_q,      state_d;
    logic [AW-1:0] rd_addr_q,    rd_addr_d;
    logic          rd_en_q,      rd_en_d;
    logic [AW-1:0] wr_addr_q,    wr_addr_d;
    logic          wr_en_q,      wr_en_d;
    logic          acc_clr_q,    acc_clr_d;
    logic          epoch_done_q, epoch_done_d;
    logic [AW-1:0] wr_ptr_q,     wr_ptr_d;
    logic [AW-1:0] base_addr;

    stage_basetable #(
        .Na (Na),
        .Nc (Nc),
        .AW (AW)
    ) u_basetable (
        .clk         (clk),
        .rst         (rst),
        .count_stage (count_stage),
        .count_step  (count_step),
        .base_addr   (base_addr)
    );

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_ptr_d  = wr_ptr_q;
        rd_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        acc_clr_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else begin
                    rd_addr_d = base_addr;
                    rd_en_d   = 1'b1;
                    acc_clr_d = (count_step == '0);
                    if (last_step) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = wr_ptr_q;
                        wr_ptr_d  = wr_ptr_q + 1'b1;
                        if (count_stage == c_LAST_STAGE && count_epoch == stop_epoch)
                            state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                state_d = en ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                if (!en) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Returning to IDLE (abort or completion) drops any pending write and clears the pointer.
        if (state_d == ST_IDLE) begin
            rd_addr_d = '0;
            wr_addr_d = '0;
            wr_ptr_d  = '0;
        end
        epoch_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rd_addr_q    <= '0;
            rd_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_en_q      <= 1'b0;
            acc_clr_q    <= 1'b0;
            epoch_done_q <= 1'b0;
            wr_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            rd_en_q      <= rd_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_en_q      <= wr_en_d;
            acc_clr_q    <= acc_clr_d;
            epoch_done_q <= epoch_done_d;
            wr_ptr_q     <= wr_ptr_d;
        end
    end

    assign rd_addr    = rd_addr_q;
    assign rd_en      = rd_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_en      = wr_en_q;
    assign acc_clr    = acc_clr_q;
    assign epoch_done = epoch_done_q;

endmodule
`default_nettype wire
